// File: rtl/alarm_ctrl_if.sv
// Alarm controller bus: wall-clock time and user controls in, alarm settings and status out.
interface alarm_ctrl_if;
   logic [7:0] hour;
   logic [7:0] min;
   logic       set_en;
   logic       inc_hour;
   logic       inc_min;
   logic       arm_tog;
   logic       snooze;
   logic       stop;
   logic [7:0] ahour;
   logic [7:0] amin;
   logic       armed;
   logic       Sound;
   logic       snoozing;

   modport master (
      output hour, min, set_en, inc_hour, inc_min, arm_tog, snooze, stop,
      input  ahour, amin, armed, Sound, snoozing
   );

   modport slave (
      input  hour, min, set_en, inc_hour, inc_min, arm_tog, snooze, stop,
      output ahour, amin, armed, Sound, snoozing
   );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: BCD alarm-time editing, edge-triggered ring with
// auto-stop, and snooze, sharing one down-counter between ring and snooze.
module alarm_ctrl #(
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned SNOOZE_SEC = 300
) (
   input logic         clk1hz,
   input logic         rst_n,
   alarm_ctrl_if.slave bus
);

   localparam int unsigned MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int unsigned CNT_W   = ($clog2(MAX_SEC) > 9) ? $clog2(MAX_SEC) : 9;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_RING   = 2'd2;
   localparam logic [1:0] S_SNOOZE = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       ahour_q, amin_q;
   logic             armed_q, sound_q, snoozing_q;
   logic             match_c, match_q, trigger_c;

   // BCD increment with wrap at top; any out-of-range value wraps to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] hi_max,
                                          input logic [7:0] top);
      logic [7:0] r;
      if ((v[7:4] > hi_max) || (v[3:0] > 4'd9) || (v >= top)) r = 8'h00;
      else if (v[3:0] == 4'd9)                                r = {4'(v[7:4] + 4'd1), 4'h0};
      else                                                    r = 8'(v + 8'd1);
      return r;
   endfunction

   assign match_c   = (bus.hour == ahour_q) && (bus.min == amin_q);
   assign trigger_c = match_c && !match_q && !bus.set_en;

   // Next-state and counter logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (bus.arm_tog) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.arm_tog) state_nxt = S_IDLE;
            else if (trigger_c) begin
               state_nxt = S_RING;
               cnt_nxt   = CNT_W'(RING_SEC - 1);
            end
         end
         S_RING: begin
            if (bus.arm_tog)                 state_nxt = S_IDLE;
            else if (bus.set_en || bus.stop) state_nxt = S_WAIT;
            else if (bus.snooze) begin
               state_nxt = S_SNOOZE;
               cnt_nxt   = CNT_W'(SNOOZE_SEC - 1);
            end
            else if (cnt == '0)              state_nxt = S_WAIT;
            else                             cnt_nxt   = cnt - CNT_W'(1);
         end
         S_SNOOZE: begin
            if (bus.arm_tog)                 state_nxt = S_IDLE;
            else if (bus.set_en || bus.stop) state_nxt = S_WAIT;
            else if (cnt == '0) begin
               state_nxt = S_RING;
               cnt_nxt   = CNT_W'(RING_SEC - 1);
            end
            else                             cnt_nxt   = cnt - CNT_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counter and status flags; match_q resets high so 00:00 at power-up is not an edge
   always_ff @(posedge clk1hz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         match_q    <= 1'b1;
         armed_q    <= 1'b0;
         sound_q    <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         match_q    <= match_c;
         armed_q    <= (state_nxt != S_IDLE);
         sound_q    <= (state_nxt == S_RING);
         snoozing_q <= (state_nxt == S_SNOOZE);
      end
   end

   // Alarm time editing
   always_ff @(posedge clk1hz or negedge rst_n) begin
      if (!rst_n) begin
         ahour_q <= 8'h00;
         amin_q  <= 8'h00;
      end else if (bus.set_en) begin
         if (bus.inc_hour) ahour_q <= bcd_inc(ahour_q, 4'd2, 8'h23);
         if (bus.inc_min)  amin_q  <= bcd_inc(amin_q, 4'd5, 8'h59);
      end
   end

   assign bus.ahour    = ahour_q;
   assign bus.amin     = amin_q;
   assign bus.armed    = armed_q;
   assign bus.Sound    = sound_q;
   assign bus.snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with default ring/snooze durations.
module tb_alarm_ctrl;

   logic clk1hz;
   logic rst_n;
   int   checks;
   int   errors;

   alarm_ctrl_if bus ();

   alarm_ctrl #(.RING_SEC(60), .SNOOZE_SEC(300)) dut (
      .clk1hz (clk1hz),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk1hz = 1'b0;
   always #5 clk1hz = ~clk1hz;

   task automatic tick();
      @(posedge clk1hz);
      #1;
   endtask

   task automatic pulse_arm();
      bus.arm_tog = 1'b1;
      tick();
      bus.arm_tog = 1'b0;
   endtask

   task automatic inc_min_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.inc_min = 1'b1;
         tick();
         bus.inc_min = 1'b0;
      end
   endtask

   task automatic inc_hour_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.inc_hour = 1'b1;
         tick();
         bus.inc_hour = 1'b0;
      end
   endtask

   task automatic start_ring(input logic [7:0] pre_min);
      bus.min = pre_min;
      tick();
      bus.min = 8'h30;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.hour = 8'h00; bus.min = 8'h00; bus.set_en = 1'b0;
      bus.inc_hour = 1'b0; bus.inc_min = 1'b0; bus.arm_tog = 1'b0;
      bus.snooze = 1'b0; bus.stop = 1'b0;
      #3;
      checks++; if (bus.ahour !== 8'h00) begin errors++; $display("FAIL rst_ahour: got %h exp 00", bus.ahour); end
      checks++; if (bus.amin !== 8'h00) begin errors++; $display("FAIL rst_amin: got %h exp 00", bus.amin); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL rst_armed: got %b exp 0", bus.armed); end
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL rst_sound: got %b exp 0", bus.Sound); end
      checks++; if (bus.snoozing !== 1'b0) begin errors++; $display("FAIL rst_snoozing: got %b exp 0", bus.snoozing); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      pulse_arm();
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL pwrup_armed: got %b exp 1", bus.armed); end
      repeat (3) tick();
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL pwrup_no_trigger: got %b exp 0", bus.Sound); end
      pulse_arm();
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL pwrup_disarm: got %b exp 0", bus.armed); end
   endtask

   task automatic test_set_time();
      bus.hour = 8'h12; bus.min = 8'h00;
      bus.set_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         bus.inc_min  = 1'b1;
         bus.inc_hour = (i < 7);
         tick();
         bus.inc_min  = 1'b0;
         bus.inc_hour = 1'b0;
      end
      bus.set_en = 1'b0;
      tick();
      checks++; if (bus.ahour !== 8'h07) begin errors++; $display("FAIL set_ahour: got %h exp 07", bus.ahour); end
      checks++; if (bus.amin !== 8'h30) begin errors++; $display("FAIL set_amin: got %h exp 30", bus.amin); end
      bus.inc_hour = 1'b1; bus.inc_min = 1'b1;
      tick();
      bus.inc_hour = 1'b0; bus.inc_min = 1'b0;
      checks++; if (bus.ahour !== 8'h07) begin errors++; $display("FAIL noedit_ahour: got %h exp 07", bus.ahour); end
      checks++; if (bus.amin !== 8'h30) begin errors++; $display("FAIL noedit_amin: got %h exp 30", bus.amin); end
      bus.set_en = 1'b1;
      inc_hour_n(16);
      checks++; if (bus.ahour !== 8'h23) begin errors++; $display("FAIL hour_23: got %h exp 23", bus.ahour); end
      inc_hour_n(1);
      checks++; if (bus.ahour !== 8'h00) begin errors++; $display("FAIL hour_wrap: got %h exp 00", bus.ahour); end
      inc_hour_n(7);
      bus.set_en = 1'b0;
      tick();
   endtask

   task automatic test_min_wrap();
      bus.set_en = 1'b1;
      inc_min_n(29);
      checks++; if (bus.amin !== 8'h59) begin errors++; $display("FAIL min_59: got %h exp 59", bus.amin); end
      inc_min_n(1);
      checks++; if (bus.amin !== 8'h00) begin errors++; $display("FAIL min_wrap: got %h exp 00", bus.amin); end
      checks++; if (bus.ahour !== 8'h07) begin errors++; $display("FAIL min_no_carry: got %h exp 07", bus.ahour); end
      inc_min_n(9);
      checks++; if (bus.amin !== 8'h09) begin errors++; $display("FAIL min_09: got %h exp 09", bus.amin); end
      inc_min_n(1);
      checks++; if (bus.amin !== 8'h10) begin errors++; $display("FAIL min_bcd_carry: got %h exp 10", bus.amin); end
      inc_min_n(20);
      checks++; if (bus.amin !== 8'h30) begin errors++; $display("FAIL min_30: got %h exp 30", bus.amin); end
      bus.set_en = 1'b0;
      tick();
   endtask

   task automatic test_ring();
      int hi;
      bus.hour = 8'h07; bus.min = 8'h29;
      pulse_arm();
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL ring_armed: got %b exp 1", bus.armed); end
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL ring_pre: got %b exp 0", bus.Sound); end
      start_ring(8'h29);
      checks++; if (bus.Sound !== 1'b1) begin errors++; $display("FAIL ring_start: got %b exp 1", bus.Sound); end
      hi = 0;
      for (int i = 0; i < 59; i++) begin
         tick();
         if (bus.Sound === 1'b1) hi++;
      end
      checks++; if (hi != 59) begin errors++; $display("FAIL ring_len: got %0d exp 59", hi); end
      tick();
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL ring_timeout: got %b exp 0", bus.Sound); end
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL ring_still_armed: got %b exp 1", bus.armed); end
      repeat (5) tick();
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL ring_no_retrigger: got %b exp 0", bus.Sound); end
   endtask

   task automatic test_snooze();
      int ok;
      start_ring(8'h29);
      checks++; if (bus.Sound !== 1'b1) begin errors++; $display("FAIL snz_ring: got %b exp 1", bus.Sound); end
      repeat (9) tick();
      bus.snooze = 1'b1;
      tick();
      bus.snooze = 1'b0;
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL snz_sound_off: got %b exp 0", bus.Sound); end
      checks++; if (bus.snoozing !== 1'b1) begin errors++; $display("FAIL snz_on: got %b exp 1", bus.snoozing); end
      ok = 0;
      for (int i = 0; i < 299; i++) begin
         bus.snooze = (i == 100);
         tick();
         bus.snooze = 1'b0;
         if (bus.snoozing === 1'b1 && bus.Sound === 1'b0) ok++;
      end
      checks++; if (ok != 299) begin errors++; $display("FAIL snz_len: got %0d exp 299", ok); end
      tick();
      checks++; if (bus.Sound !== 1'b1) begin errors++; $display("FAIL snz_rering: got %b exp 1", bus.Sound); end
      checks++; if (bus.snoozing !== 1'b0) begin errors++; $display("FAIL snz_off: got %b exp 0", bus.snoozing); end
      repeat (2) tick();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL stop_sound: got %b exp 0", bus.Sound); end
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL stop_armed: got %b exp 1", bus.armed); end
      repeat (5) tick();
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL stop_no_retrigger: got %b exp 0", bus.Sound); end
   endtask

   task automatic test_arm_stop();
      start_ring(8'h29);
      checks++; if (bus.Sound !== 1'b1) begin errors++; $display("FAIL armstop_ring: got %b exp 1", bus.Sound); end
      bus.arm_tog = 1'b1; bus.stop = 1'b1;
      tick();
      bus.arm_tog = 1'b0; bus.stop = 1'b0;
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL armstop_sound: got %b exp 0", bus.Sound); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL armstop_armed: got %b exp 0", bus.armed); end
   endtask

   task automatic test_set_en_exit();
      pulse_arm();
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL seten_armed: got %b exp 1", bus.armed); end
      start_ring(8'h29);
      checks++; if (bus.Sound !== 1'b1) begin errors++; $display("FAIL seten_ring: got %b exp 1", bus.Sound); end
      bus.set_en = 1'b1;
      tick();
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL seten_quiet: got %b exp 0", bus.Sound); end
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL seten_wait: got %b exp 1", bus.armed); end
      repeat (3) tick();
      bus.set_en = 1'b0;
      repeat (3) tick();
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL seten_exit_no_trigger: got %b exp 0", bus.Sound); end
   endtask

   task automatic test_reset_snooze();
      start_ring(8'h31);
      checks++; if (bus.Sound !== 1'b1) begin errors++; $display("FAIL rsnz_ring: got %b exp 1", bus.Sound); end
      bus.snooze = 1'b1;
      tick();
      bus.snooze = 1'b0;
      checks++; if (bus.snoozing !== 1'b1) begin errors++; $display("FAIL rsnz_snooze: got %b exp 1", bus.snoozing); end
      repeat (37) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.snoozing !== 1'b0) begin errors++; $display("FAIL rsnz_snoozing: got %b exp 0", bus.snoozing); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL rsnz_armed: got %b exp 0", bus.armed); end
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL rsnz_sound: got %b exp 0", bus.Sound); end
      checks++; if (bus.ahour !== 8'h00) begin errors++; $display("FAIL rsnz_ahour: got %h exp 00", bus.ahour); end
      checks++; if (bus.amin !== 8'h00) begin errors++; $display("FAIL rsnz_amin: got %h exp 00", bus.amin); end
      #2 rst_n = 1'b1;
      tick();
      bus.hour = 8'h00; bus.min = 8'h59;
      tick();
      bus.min = 8'h00;
      repeat (4) tick();
      checks++; if (bus.Sound !== 1'b0) begin errors++; $display("FAIL rsnz_no_resume: got %b exp 0", bus.Sound); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL rsnz_disarmed: got %b exp 0", bus.armed); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_set_time();
      test_min_wrap();
      test_ring();
      test_snooze();
      test_arm_stop();
      test_set_en_exit();
      test_reset_snooze();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
